wb_cw_bridge: RTL and testbench

WB_CW_BRIDGE -- requirements
Module: wb_cw_bridge

---
 rtl/wb_cw_bridge.sv | 153 +++++++++++++++
 tb/tb_wb_cw_bridge.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cw_bridge.sv
// CW-to-Wishbone bridge: decodes a header/address/data frame from the compressor
// into single or burst Wishbone master cycles and returns per-beat ack/err pulses.
module wb_cw_bridge #(
    parameter int ADDR_W = 24
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              cw_req,
    input  logic              cw_dir,
    input  logic [15:0]       cw_io_i,
    output logic [15:0]       cw_io_o,
    output logic              cw_ack,
    output logic              cw_err,
    output logic              wb_cyc,
    output logic              wb_stb,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_adr,
    output logic [15:0]       wb_o_dat,
    output logic [1:0]        wb_sel,
    input  logic [15:0]       wb_i_dat,
    input  logic              wb_ack,
    input  logic              wb_err,
    output logic [2:0]        dbg_state
);

    // Handshake: a beat on the bus completes on the first rising edge where
    // wb_stb=1 and (wb_ack|wb_err)=1; the CW side sees exactly one cw_ack or
    // cw_err cycle per completed beat, and cw_req low at any point abandons the frame.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_WDATA    = 3'd2,
        S_BUS      = 3'd3,
        S_RESP     = 3'd4,
        S_WAIT_REL = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [1:0]          sel_q, sel_d;
    logic [7:0]          adr_hi_q, adr_hi_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [15:0]         wdat_q, wdat_d;
    logic [15:0]         rdat_q, rdat_d;
    logic                err_q, err_d;
    logic [3:0]          beats_q, beats_d;
    logic                unused_hdr_bits;

    assign unused_hdr_bits = ^cw_io_i[10:8];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (cw_req) state_d = S_ADDR;
            S_ADDR:     state_d = !cw_req ? S_IDLE : (we_q ? S_WDATA : S_BUS);
            S_WDATA:    state_d = !cw_req ? S_IDLE : S_BUS;
            S_BUS: begin
                if (!cw_req)               state_d = S_IDLE;
                else if (wb_ack || wb_err) state_d = S_RESP;
            end
            S_RESP: begin
                if (!cw_req)                      state_d = S_IDLE;
                else if (!err_q && beats_q > 4'd1) state_d = we_q ? S_WDATA : S_BUS;
                else                              state_d = S_WAIT_REL;
            end
            S_WAIT_REL: if (!cw_req) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cyc_d    = cyc_q;
        we_d     = we_q;
        sel_d    = sel_q;
        adr_hi_d = adr_hi_q;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        rdat_d   = rdat_q;
        err_d    = err_q;
        beats_d  = beats_q;
        case (state_q)
            S_IDLE: if (cw_req) begin
                we_d     = cw_io_i[15];
                sel_d    = cw_io_i[14:13];
                adr_hi_d = cw_io_i[7:0];
                err_d    = 1'b0;
                beats_d  = cw_io_i[11] ? 4'd8 : (cw_io_i[12] ? 4'd4 : 4'd1);
            end
            S_ADDR:  adr_d  = ADDR_W'({adr_hi_q, cw_io_i});
            S_WDATA: wdat_d = cw_io_i;
            S_BUS: begin
                if (wb_ack)           rdat_d = wb_i_dat;
                if (wb_ack || wb_err) err_d  = wb_err;
            end
            S_RESP: begin
                if (state_d == S_BUS || state_d == S_WDATA) begin
                    adr_d   = adr_q + ADDR_W'(1);
                    beats_d = beats_q - 4'd1;
                end else begin
                    beats_d = 4'd0;
                end
            end
            default: ;
        endcase
        // The cycle stays open across inter-beat RESP/WDATA and closes when the frame ends.
        if (state_d == S_BUS)                             cyc_d = 1'b1;
        else if (state_d == S_IDLE || state_d == S_WAIT_REL) cyc_d = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= 2'b00;
            adr_hi_q <= 8'h00;
            adr_q    <= '0;
            wdat_q   <= 16'h0000;
            rdat_q   <= 16'h0000;
            err_q    <= 1'b0;
            beats_q  <= 4'd0;
        end else begin
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            adr_hi_q <= adr_hi_d;
            adr_q    <= adr_d;
            wdat_q   <= wdat_d;
            rdat_q   <= rdat_d;
            err_q    <= err_d;
            beats_q  <= beats_d;
        end
    end

    always_comb begin
        wb_cyc    = cyc_q;
        wb_stb    = (state_q == S_BUS);
        wb_we     = we_q;
        wb_sel    = sel_q;
        wb_adr    = adr_q;
        wb_o_dat  = wdat_q;
        cw_ack    = (state_q == S_RESP) && cw_req && !err_q;
        cw_err    = (state_q == S_RESP) && cw_req && err_q;
        cw_io_o   = (cw_ack && !we_q && cw_dir) ? rdat_q : 16'h0000;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_wb_cw_bridge.sv
// Directed bench for wb_cw_bridge: a table of frames run through a CW driver and
// a Wishbone slave model, plus hand-written abort and mid-burst reset sequences.
module tb_wb_cw_bridge;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_BUS   = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd5;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        cw_req = 1'b0;
    logic        cw_dir = 1'b0;
    logic [15:0] cw_io_i = 16'h0;
    logic [15:0] cw_io_o;
    logic        cw_ack, cw_err;
    logic        wb_cyc, wb_stb, wb_we;
    logic [23:0] wb_adr;
    logic [15:0] wb_o_dat;
    logic [1:0]  wb_sel;
    logic [15:0] wb_i_dat = 16'h0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [23:0] exp_q[$];

    typedef struct {
        logic [15:0] hdr;
        logic [15:0] adr;
        logic        dir;
        int          ws;
        int          err_beat;
        logic        both;
        logic [15:0] base;
        logic [23:0] exp_start;
        int          exp_beats;
    } vec_t;

    vec_t vecs[7];

    wb_cw_bridge #(.ADDR_W(24)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .cw_req(cw_req), .cw_dir(cw_dir), .cw_io_i(cw_io_i), .cw_io_o(cw_io_o),
        .cw_ack(cw_ack), .cw_err(cw_err),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_o_dat(wb_o_dat), .wb_sel(wb_sel),
        .wb_i_dat(wb_i_dat), .wb_ack(wb_ack), .wb_err(wb_err),
        .dbg_state(dbg_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cw(input logic [15:0] adr, input logic [15:0] data);
        case (dbg_state)
            ST_ADDR:  cw_io_i = adr;
            ST_WDATA: cw_io_i = data;
            default:  cw_io_i = 16'h0;
        endcase
    endtask

    task automatic run_frame(input vec_t v);
        int beat, ws_cnt, acks, errs, cycles, n_bus, first_lat, exp_lat;
        logic started, cyc_ok, stb_after_err, done, is_wr, wait_ok;
        logic [15:0] exp_rd;
        logic [23:0] exp_a;
        is_wr = v.hdr[15];
        n_bus = (v.err_beat != 0) ? v.err_beat : v.exp_beats;
        exp_q.delete();
        for (int i = 0; i < n_bus; i++) exp_q.push_back(v.exp_start + 24'(i));
        beat = 0; ws_cnt = 0; acks = 0; errs = 0; cycles = 0; first_lat = -1;
        started = 1'b0; cyc_ok = 1'b1; stb_after_err = 1'b0; done = 1'b0;
        @(negedge i_clk);
        cw_dir = v.dir; cw_req = 1'b1; cw_io_i = v.hdr;
        while (!done && cycles < 300) begin
            @(negedge i_clk);
            cycles++;
            if (cw_ack || cw_err) begin
                if (first_lat < 0) first_lat = cycles;
                exp_rd = (!is_wr && v.dir && cw_ack) ? v.base + 16'(beat) : 16'h0;
                check("cw_io_o", 32'(cw_io_o), 32'(exp_rd));
                if (cw_ack) acks++;
                else        errs++;
                beat++;
            end
            if (errs > 0 && wb_stb) stb_after_err = 1'b1;
            if (started && dbg_state != ST_WAIT && !wb_cyc) cyc_ok = 1'b0;
            wb_ack = 1'b0; wb_err = 1'b0; wb_i_dat = 16'h0;
            if (wb_stb) begin
                started = 1'b1;
                if (ws_cnt == 0) begin
                    if (exp_q.size() == 0) begin
                        check("extra_stb", 32'd1, 32'd0);
                    end else begin
                        exp_a = exp_q.pop_front();
                        check("wb_adr", 32'(wb_adr), 32'(exp_a));
                    end
                    check("wb_we", 32'(wb_we), 32'(is_wr));
                    check("wb_sel", 32'(wb_sel), 32'(v.hdr[14:13]));
                    if (is_wr) check("wb_o_dat", 32'(wb_o_dat), 32'(v.base + 16'(beat)));
                end
                if (ws_cnt == v.ws) begin
                    if (beat + 1 == v.err_beat) begin
                        wb_err = 1'b1; wb_ack = v.both; wb_i_dat = 16'hDEAD;
                    end else begin
                        wb_ack = 1'b1; wb_i_dat = v.base + 16'(beat);
                    end
                    ws_cnt = 0;
                end else begin
                    ws_cnt++;
                end
            end
            drive_cw(v.adr, v.base + 16'(beat));
            if (dbg_state == ST_WAIT) done = 1'b1;
        end
        check("frame_done", 32'(done), 32'd1);
        exp_lat = (is_wr ? 4 : 3) + v.ws;
        check("latency", 32'(first_lat), 32'(exp_lat));
        check("ack_count", 32'(acks), 32'((v.err_beat != 0) ? v.err_beat - 1 : v.exp_beats));
        check("err_count", 32'(errs), 32'((v.err_beat != 0) ? 1 : 0));
        check("beats_left", 32'(exp_q.size()), 32'd0);
        check("cyc_held", 32'(cyc_ok), 32'd1);
        check("stb_after_err", 32'(stb_after_err), 32'd0);
        wait_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            if (dbg_state != ST_WAIT || wb_cyc || wb_stb || cw_ack || cw_err) wait_ok = 1'b0;
        end
        check("wait_rel_hold", 32'(wait_ok), 32'd1);
        cw_req = 1'b0;
        @(negedge i_clk);
        check("back_to_idle", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cyc"}, 32'(wb_cyc), 32'd0);
        check({tag, "_stb"}, 32'(wb_stb), 32'd0);
        check({tag, "_we"}, 32'(wb_we), 32'd0);
        check({tag, "_adr"}, 32'(wb_adr), 32'd0);
        check({tag, "_odat"}, 32'(wb_o_dat), 32'd0);
        check({tag, "_sel"}, 32'(wb_sel), 32'd0);
        check({tag, "_cwo"}, 32'(cw_io_o), 32'd0);
        check({tag, "_ackerr"}, 32'({cw_ack, cw_err}), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        int cyc;
        logic seen;
        //          hdr      adr      dir  ws err both base     start       beats
        vecs[0] = '{16'h0001, 16'h1001, 1'b1, 2, 0, 1'b0, 16'hBEEF, 24'h011001, 1};
        vecs[1] = '{16'hF000, 16'h0010, 1'b1, 0, 0, 1'b0, 16'h0001, 24'h000010, 4};
        vecs[2] = '{16'h08FF, 16'hFFFE, 1'b1, 0, 0, 1'b0, 16'h1000, 24'hFFFFFE, 8};
        vecs[3] = '{16'h1000, 16'h0020, 1'b1, 1, 2, 1'b0, 16'hA000, 24'h000020, 4};
        vecs[4] = '{16'hB812, 16'h3456, 1'b1, 1, 0, 1'b0, 16'h0100, 24'h123456, 8};
        vecs[5] = '{16'h0755, 16'h0000, 1'b0, 0, 0, 1'b0, 16'h5555, 24'h550000, 1};
        vecs[6] = '{16'hC000, 16'h0100, 1'b1, 0, 1, 1'b1, 16'h0042, 24'h000100, 1};

        repeat (2) @(negedge i_clk);
        check_all_zero("reset");
        i_rst = 1'b1;
        @(negedge i_clk);

        for (int k = 0; k < 7; k++) run_frame(vecs[k]);

        // Abort: drop cw_req while a write beat is stalled on the bus.
        @(negedge i_clk);
        cw_dir = 1'b1; cw_req = 1'b1; cw_io_i = 16'h8000;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge i_clk);
            cyc++;
            if (dbg_state == ST_BUS) seen = 1'b1;
            drive_cw(16'h0040, 16'h7777);
        end
        check("abort_reach_bus", 32'(seen), 32'd1);
        check("abort_cyc_before", 32'(wb_cyc), 32'd1);
        cw_req = 1'b0;
        @(negedge i_clk);
        check("abort_cyc", 32'(wb_cyc), 32'd0);
        check("abort_stb", 32'(wb_stb), 32'd0);
        check("abort_ackerr", 32'({cw_ack, cw_err}), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        run_frame(vecs[0]);

        // Reset during the second beat of a burst4 read.
        @(negedge i_clk);
        cw_dir = 1'b1; cw_req = 1'b1; cw_io_i = 16'h1000;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 30) begin
            @(negedge i_clk);
            cyc++;
            wb_ack = 1'b0;
            if (cw_ack && dbg_state != ST_BUS) seen = 1'b0;
            if (dbg_state == ST_BUS && wb_adr == 24'h000201) seen = 1'b1;
            else if (wb_stb) begin wb_ack = 1'b1; wb_i_dat = 16'h1234; end
            drive_cw(16'h0200, 16'h0);
        end
        check("rst_reach_beat2", 32'(seen), 32'd1);
        check("rst_cyc_before", 32'(wb_cyc), 32'd1);
        #2 i_rst = 1'b0;
        #1 check_all_zero("midrst");
        cw_req = 1'b0; wb_ack = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("post_rst_idle", 32'(dbg_state), 32'(ST_IDLE));
        run_frame(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
